// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Signed operands are reduced to magnitudes at capture, an unsigned
// shift-add multiplier or restoring divider runs for 32 iterations, and
// the sign is restored when the last iteration is written back.
// Divide-by-zero and signed overflow complete in one cycle.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle 33x33 signed
// multiplier for MUL/MULH/MULHSU/MULHU; division stays iterative).
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ALL_ZERO  = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [5:0]      LAST_ITER = 6'd31;

   state_t              state_r, state_nxt_s;
   logic [5:0]          cnt_r;
   logic [2:0]          op_r;
   logic [4:0]          rd_r;
   logic [XLEN-1:0]     a_mag_r, b_mag_r;
   logic                neg_r;
   logic [2*XLEN-1:0]   acc_r;
   logic [XLEN-1:0]     result_r;
   logic [4:0]          rd_out_r;
   logic                done_r, busy_r;

   logic                a_signed_s, b_signed_s, sign_a_s, sign_b_s, neg_s;
   logic [XLEN-1:0]     a_mag_s, b_mag_s, special_res_s;
   logic                div_zero_s, ovf_s, special_s, fast_s;
   logic [XLEN-1:0]     fast_res_s;
   logic [XLEN:0]       mul_sum_s, div_shift_s, div_diff_s;
   logic [2*XLEN-1:0]   iter_nxt_s, fixed_prod_s;
   logic [XLEN-1:0]     div_pick_s, final_res_s;

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;
   assign rd_out = rd_out_r;

   // Decode operand signedness, magnitudes, result sign and special cases at capture
   always_comb begin
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      case (funct3)
         3'b001:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
         3'b010:  begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
         3'b100:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
         3'b110:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
         default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
      endcase
      sign_a_s = a_signed_s & operand_a[XLEN-1];
      sign_b_s = b_signed_s & operand_b[XLEN-1];
      if (sign_a_s) a_mag_s = -operand_a;
      else          a_mag_s = operand_a;
      if (sign_b_s) b_mag_s = -operand_b;
      else          b_mag_s = operand_b;
      // REM takes the dividend's sign; every other signed op uses the XOR
      if (funct3 == 3'b110) neg_s = sign_a_s;
      else                  neg_s = sign_a_s ^ sign_b_s;
      div_zero_s = funct3[2] & (operand_b == ALL_ZERO);
      ovf_s      = funct3[2] & ~funct3[0] & (operand_a == INT_MIN) & (operand_b == ALL_ONES);
      special_s  = div_zero_s | ovf_s;
      if (div_zero_s)  special_res_s = funct3[1] ? operand_a : ALL_ONES;
      else if (ovf_s)  special_res_s = funct3[1] ? ALL_ZERO : INT_MIN;
      else             special_res_s = ALL_ZERO;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*XLEN+1:0] fast_prod_s;

   // Single-cycle 33x33 signed product; the extra bit carries each operand's signedness
   always_comb begin
      fast_prod_s = $signed({a_signed_s & operand_a[XLEN-1], operand_a}) *
                    $signed({b_signed_s & operand_b[XLEN-1], operand_b});
      if (funct3[1:0] == 2'b00) fast_res_s = fast_prod_s[XLEN-1:0];
      else                      fast_res_s = fast_prod_s[2*XLEN-1:XLEN];
   end
   assign fast_s = ~funct3[2];
`else
   assign fast_s     = 1'b0;
   assign fast_res_s = ALL_ZERO;
`endif

   // One shift-add or restoring-divide step, plus the sign-corrected final result
   always_comb begin
      mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, (acc_r[0] ? a_mag_r : ALL_ZERO)};
      div_shift_s = acc_r[2*XLEN-1:XLEN-1];
      div_diff_s  = div_shift_s - {1'b0, b_mag_r};
      if (op_r[2]) begin
         // Borrow out of the trial subtraction means the divisor did not fit
         if (div_diff_s[XLEN]) iter_nxt_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
         else                  iter_nxt_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
         iter_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
      end
      if (neg_r) fixed_prod_s = -iter_nxt_s;
      else       fixed_prod_s = iter_nxt_s;
      if (op_r[1]) div_pick_s = iter_nxt_s[2*XLEN-1:XLEN];
      else         div_pick_s = iter_nxt_s[XLEN-1:0];
      if (op_r[2]) begin
         if (neg_r) final_res_s = -div_pick_s;
         else       final_res_s = div_pick_s;
      end else if (op_r[1:0] == 2'b00) begin
         final_res_s = fixed_prod_s[XLEN-1:0];
      end else begin
         final_res_s = fixed_prod_s[2*XLEN-1:XLEN];
      end
   end

   // Next-state logic: flush beats start, single-step ops skip CALC
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start && !flush) state_nxt_s = (special_s || fast_s) ? ST_DONE : ST_CALC;
            else                 state_nxt_s = ST_IDLE;
         end
         ST_CALC: begin
            if (flush)                   state_nxt_s = ST_IDLE;
            else if (cnt_r == LAST_ITER) state_nxt_s = ST_DONE;
            else                         state_nxt_s = ST_CALC;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register with registered busy/done decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         done_r  <= (state_nxt_s == ST_DONE);
         busy_r  <= (state_nxt_s != ST_IDLE);
      end
   end

   // Operand capture, iteration datapath and write-back registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= 6'd0;
         op_r     <= 3'd0;
         rd_r     <= 5'd0;
         a_mag_r  <= ALL_ZERO;
         b_mag_r  <= ALL_ZERO;
         neg_r    <= 1'b0;
         acc_r    <= {2*XLEN{1'b0}};
         result_r <= ALL_ZERO;
         rd_out_r <= 5'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start && !flush) begin
                  op_r    <= funct3;
                  rd_r    <= rd_in;
                  a_mag_r <= a_mag_s;
                  b_mag_r <= b_mag_s;
                  neg_r   <= neg_s;
                  cnt_r   <= 6'd0;
                  if (special_s) begin
                     result_r <= special_res_s;
                     rd_out_r <= rd_in;
                  end else if (fast_s) begin
                     result_r <= fast_res_s;
                     rd_out_r <= rd_in;
                  end else if (funct3[2]) begin
                     acc_r <= {ALL_ZERO, a_mag_s};
                  end else begin
                     acc_r <= {ALL_ZERO, b_mag_s};
                  end
               end
            end
            ST_CALC: begin
               if (!flush) begin
                  acc_r <= iter_nxt_s;
                  cnt_r <= cnt_r + 6'd1;
                  if (cnt_r == LAST_ITER) begin
                     result_r <= final_res_s;
                     rd_out_r <= rd_r;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
